log_event_arbiter: RTL and testbench
====================================

LOG_EVENT_ARBITER -- requirements
Module: log_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of message requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, message payload width.
REQ-003 SHALL have parameter TS_WIDTH, default 32, timestamp counter width.
REQ-004 SHALL have parameter ERR_CNT_WIDTH, default 16, error counter width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port s_valid  input  NUM_REQ  per-requester message valid.
REQ-008 SHALL have port s_ready  output  NUM_REQ  per-requester accept.
REQ-009 SHALL have port s_level  input  2*NUM_REQ  per-requester level (0 error, 1 warning, 2 info, 3 debug).
REQ-010 SHALL have port s_data  input  DATA_WIDTH*NUM_REQ  per-requester payload.
REQ-011 SHALL have port verbosity  input  2  maximum level forwarded.
REQ-012 SHALL have port halt_on_error  input  1  enables halt after a forwarded error.
REQ-013 SHALL have port clear_halt  input  1  single-cycle pulse leaving HALT.
REQ-014 SHALL have port m_valid  output  1  output message valid.
REQ-015 SHALL have port m_ready  input  1  downstream accept.
REQ-016 SHALL have port m_level/m_src/m_data/m_timestamp  output  2/clog2(NUM_REQ)/DATA_WIDTH/TS_WIDTH  forwarded message fields.
REQ-017 SHALL have port error_count  output  ERR_CNT_WIDTH  accepted level-0 messages.
REQ-018 SHALL have port halted  output  1  high in HALT state.

Function
REQ-019 SHALL run a free-running TS_WIDTH timestamp counter, +1 per cycle, wrapping all-ones to 0.
REQ-020 SHALL select at most one requester per cycle, round-robin starting at the pointer; pointer resets to 0 and becomes (granted+1) mod NUM_REQ after each acceptance.
REQ-021 SHALL accept (s_ready high for the winner only) only in RUN and when the output register is empty or m_valid&&m_ready this cycle.
REQ-022 SHALL, for an accepted message with s_level <= verbosity (same-cycle value), load the output register and assert m_valid on the next cycle (latency 1), m_timestamp = counter value at acceptance cycle.
REQ-023 SHALL accept and silently discard messages with s_level > verbosity; output register unchanged; pointer still advances.
REQ-024 SHALL hold m_valid and all m_* fields stable while m_valid && !m_ready.
REQ-025 SHALL support back-to-back forwarding: with m_ready held high, one message per cycle.
REQ-026 SHALL increment error_count on every accepted level-0 message, saturating at all-ones.
REQ-027 SHALL implement states RUN and HALT: RUN->HALT on acceptance of a level-0 message with halt_on_error=1; HALT->RUN on clear_halt.
REQ-028 SHALL, in HALT, drive s_ready all-low; the pending error message remains in the output register and drains normally.
REQ-029 SHALL ignore clear_halt in RUN; clear_halt in HALT takes effect next cycle with no acceptance in the clear cycle.
REQ-030 SHALL not change state when halt_on_error deasserts while in HALT.
REQ-031 SHALL keep s_ready independent of unselected s_valid bits being low; s_ready never asserted for a requester with s_valid low.

Reset
REQ-032 SHALL, on resetn low, asynchronously clear: state=RUN, pointer=0, timestamp=0, error_count=0, m_valid=0, m_level/m_src/m_data/m_timestamp=0, s_ready=0, halted=0.
REQ-033 SHALL discard any buffered message on reset mid-operation; deassertion synchronous to clk.

Verification
REQ-034 SHALL verify: all 4 requesters valid, level 2, verbosity 2, m_ready=1 -> m_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL verify: verbosity 1, requester 2 sends level 2 data 0xA5A5A5A5 -> s_ready[2] pulses, m_valid stays 0, pointer moves to 3.
REQ-036 SHALL verify: m_ready=0 for 5 cycles with 2 requesters valid -> one message held stable, s_ready low, both delivered after m_ready=1.
REQ-037 SHALL verify: halt_on_error=1, requester 1 sends level 0 -> error_count=1, halted=1 next cycle, s_ready=0 until clear_halt, then resume.
REQ-038 SHALL verify: ERR_CNT_WIDTH=2, 5 level-0 messages with halt_on_error=0 -> error_count saturates at 3.
REQ-039 SHALL verify: resetn low while m_valid=1 -> m_valid=0, error_count=0 immediately without clock edge.

Source files
------------

// File: rtl/log_event_arbiter.sv
// rtl/log_event_arbiter.sv - round-robin log message arbiter with verbosity filter, error counting and halt-on-error
module log_event_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TS_WIDTH      = 32,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [2*NUM_REQ-1:0]          s_level,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] s_data,
  input  logic [1:0]                    verbosity,
  input  logic                          halt_on_error,
  input  logic                          clear_halt,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [1:0]                    m_level,
  output logic [SRC_W-1:0]              m_src,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [TS_WIDTH-1:0]           m_timestamp,
  output logic [ERR_CNT_WIDTH-1:0]      error_count,
  output logic                          halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [SRC_W-1:0]        ptr;
  logic [TS_WIDTH-1:0]     ts;
  logic [1:0]              lvl_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
  logic                    grant_any;
  logic [SRC_W-1:0]        grant_idx;
  logic [SRC_W-1:0]        cidx;
  int                      cand;
  logic [1:0]              sel_level;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    can_accept, accept, fwd, is_err;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      lvl_arr[k]  = s_level[2*k +: 2];
      data_arr[k] = s_data[DATA_WIDTH*k +: DATA_WIDTH];
    end
  end

  // First valid requester found scanning upward from the pointer, with wrap.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cidx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      cidx = SRC_W'(cand);
      if (!grant_any && s_valid[cidx]) begin
        grant_any = 1'b1;
        grant_idx = cidx;
      end
    end
  end

  assign sel_level  = lvl_arr[grant_idx];
  assign sel_data   = data_arr[grant_idx];
  assign can_accept = (state == RUN) && (!m_valid || m_ready);
  assign accept     = can_accept && grant_any;
  assign fwd        = accept && (sel_level <= verbosity);
  assign is_err     = accept && (sel_level == 2'd0);
  assign halted     = (state == HALT);

  // Gating with resetn keeps s_ready low while reset is held, even with s_valid high.
  always_comb begin
    s_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s_ready[k] = accept && resetn && (grant_idx == SRC_W'(k));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (is_err && halt_on_error) state_nxt = HALT;
      HALT:    if (clear_halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr         <= '0;
      ts          <= '0;
      error_count <= '0;
      m_valid     <= 1'b0;
      m_level     <= '0;
      m_src       <= '0;
      m_data      <= '0;
      m_timestamp <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (accept) begin
        ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
      if (is_err && (error_count != '1)) begin
        error_count <= error_count + ERR_CNT_WIDTH'(1);
      end
      if (fwd) begin
        m_valid     <= 1'b1;
        m_level     <= sel_level;
        m_src       <= grant_idx;
        m_data      <= sel_data;
        m_timestamp <= ts;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_log_event_arbiter.sv
// tb/tb_log_event_arbiter.sv - directed self-checking bench for log_event_arbiter
module tb_log_event_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready, s_ready2;
  logic [7:0]   s_level;
  logic [127:0] s_data;
  logic [1:0]   verbosity;
  logic         halt_on_error, clear_halt, m_ready;
  logic         m_valid, m_valid2;
  logic [1:0]   m_level, m_level2;
  logic [1:0]   m_src, m_src2;
  logic [31:0]  m_data, m_data2;
  logic [31:0]  m_timestamp, m_timestamp2;
  logic [15:0]  error_count;
  logic [1:0]   error_count2;
  logic         halted, halted2;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  log_event_arbiter dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_level(s_level), .s_data(s_data), .verbosity(verbosity),
    .halt_on_error(halt_on_error), .clear_halt(clear_halt),
    .m_valid(m_valid), .m_ready(m_ready), .m_level(m_level), .m_src(m_src),
    .m_data(m_data), .m_timestamp(m_timestamp), .error_count(error_count),
    .halted(halted)
  );

  log_event_arbiter #(.ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready2),
    .s_level(s_level), .s_data(s_data), .verbosity(verbosity),
    .halt_on_error(halt_on_error), .clear_halt(clear_halt),
    .m_valid(m_valid2), .m_ready(m_ready), .m_level(m_level2), .m_src(m_src2),
    .m_data(m_data2), .m_timestamp(m_timestamp2), .error_count(error_count2),
    .halted(halted2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn        = 1'b0;
    s_valid       = '0;
    s_level       = '0;
    s_data        = '0;
    verbosity     = 2'd0;
    halt_on_error = 1'b0;
    clear_halt    = 1'b0;
    m_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    s_valid = 4'b1111;
    #3;
    vectors++;
    if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_s_ready got %b expected 0000", s_ready); end
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got %b expected 0", m_valid); end
    vectors++;
    if (error_count !== 16'd0) begin miscompares++; $display("FAIL reset_error_count got %0d expected 0", error_count); end
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b expected 0", halted); end
    vectors++;
    if (m_timestamp !== 32'd0 || m_data !== 32'd0) begin miscompares++; $display("FAIL reset_fields got ts=%h data=%h expected 0/0", m_timestamp, m_data); end
  endtask

  task automatic test_round_robin;
    do_reset();
    verbosity = 2'd2;
    m_ready   = 1'b1;
    s_level   = 8'hAA;
    s_data    = {32'h103, 32'h102, 32'h101, 32'h100};
    s_valid   = 4'b1111;
    #1;
    vectors++;
    if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL rr_first_ready got %b expected 0001", s_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (m_valid !== 1'b1 || m_src !== 2'(i % 4)) begin
        miscompares++; $display("FAIL rr_src[%0d] got valid=%b src=%0d expected 1/%0d", i, m_valid, m_src, i % 4);
      end
      vectors++;
      if (m_data !== 32'h100 + 32'(i % 4) || m_timestamp !== 32'(i)) begin
        miscompares++; $display("FAIL rr_data[%0d] got data=%h ts=%0d expected %h/%0d", i, m_data, m_timestamp, 32'h100 + 32'(i % 4), i);
      end
    end
    s_valid = '0;
    step();
  endtask

  task automatic test_discard;
    do_reset();
    verbosity      = 2'd1;
    m_ready        = 1'b1;
    s_level        = 8'hAA;
    s_data[95:64]  = 32'hA5A5A5A5;
    s_valid        = 4'b0100;
    #1;
    vectors++;
    if (s_ready !== 4'b0100) begin miscompares++; $display("FAIL discard_ready got %b expected 0100", s_ready); end
    step();
    s_valid = '0;
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL discard_m_valid got %b expected 0", m_valid); end
    verbosity = 2'd2;
    s_valid   = 4'b1001;
    #1;
    vectors++;
    if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL discard_ptr_ready got %b expected 1000", s_ready); end
    step();
    s_valid = '0;
    vectors++;
    if (m_valid !== 1'b1 || m_src !== 2'd3) begin miscompares++; $display("FAIL discard_next_src got valid=%b src=%0d expected 1/3", m_valid, m_src); end
    step();
  endtask

  task automatic test_backpressure;
    do_reset();
    verbosity = 2'd3;
    m_ready   = 1'b0;
    s_level   = 8'h55;
    s_data    = {32'h0, 32'h0, 32'hBEEF0001, 32'hBEEF0000};
    s_valid   = 4'b0011;
    #1;
    vectors++;
    if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_first_ready got %b expected 0001", s_ready); end
    step();
    s_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_stall_ready[%0d] got %b expected 0000", i, s_ready); end
      vectors++;
      if (m_valid !== 1'b1 || m_src !== 2'd0 || m_data !== 32'hBEEF0000 || m_level !== 2'd1) begin
        miscompares++; $display("FAIL bp_hold[%0d] got valid=%b src=%0d data=%h lvl=%0d expected 1/0/beef0000/1", i, m_valid, m_src, m_data, m_level);
      end
      step();
    end
    m_ready = 1'b1;
    #1;
    vectors++;
    if (s_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_release_ready got %b expected 0010", s_ready); end
    step();
    s_valid = '0;
    vectors++;
    if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== 32'hBEEF0001) begin
      miscompares++; $display("FAIL bp_second got valid=%b src=%0d data=%h expected 1/1/beef0001", m_valid, m_src, m_data);
    end
    step();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b expected 0", m_valid); end
  endtask

  task automatic test_halt;
    do_reset();
    halt_on_error = 1'b1;
    verbosity     = 2'd2;
    m_ready       = 1'b0;
    s_level       = 8'h20;
    s_valid       = 4'b0010;
    #1;
    vectors++;
    if (s_ready !== 4'b0010) begin miscompares++; $display("FAIL halt_accept_ready got %b expected 0010", s_ready); end
    step();
    s_valid = 4'b0100;
    #1;
    vectors++;
    if (halted !== 1'b1 || error_count !== 16'd1) begin miscompares++; $display("FAIL halt_enter got halted=%b cnt=%0d expected 1/1", halted, error_count); end
    vectors++;
    if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL halt_ready got %b expected 0000", s_ready); end
    vectors++;
    if (m_valid !== 1'b1 || m_src !== 2'd1 || m_level !== 2'd0) begin miscompares++; $display("FAIL halt_msg got valid=%b src=%0d lvl=%0d expected 1/1/0", m_valid, m_src, m_level); end
    m_ready = 1'b1;
    step();
    vectors++;
    if (m_valid !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_drain got valid=%b halted=%b expected 0/1", m_valid, halted); end
    halt_on_error = 1'b0;
    step();
    vectors++;
    if (halted !== 1'b1 || s_ready !== 4'b0000) begin miscompares++; $display("FAIL halt_sticky got halted=%b ready=%b expected 1/0000", halted, s_ready); end
    clear_halt = 1'b1;
    #1;
    vectors++;
    if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL halt_clear_cycle_ready got %b expected 0000", s_ready); end
    step();
    clear_halt = 1'b0;
    #1;
    vectors++;
    if (halted !== 1'b0 || s_ready !== 4'b0100) begin miscompares++; $display("FAIL halt_resume got halted=%b ready=%b expected 0/0100", halted, s_ready); end
    step();
    s_valid = '0;
    vectors++;
    if (m_valid !== 1'b1 || m_src !== 2'd2 || m_level !== 2'd2) begin miscompares++; $display("FAIL halt_after got valid=%b src=%0d lvl=%0d expected 1/2/2", m_valid, m_src, m_level); end
    step();
  endtask

  task automatic test_saturation;
    do_reset();
    verbosity = 2'd0;
    m_ready   = 1'b1;
    s_level   = 8'h00;
    s_valid   = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (error_count2 !== 2'((i + 1 > 3) ? 3 : i + 1) || error_count !== 16'(i + 1)) begin
        miscompares++; $display("FAIL sat_count[%0d] got narrow=%0d wide=%0d expected %0d/%0d", i, error_count2, error_count, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
    end
    s_valid = '0;
    step();
  endtask

  task automatic test_async_reset;
    do_reset();
    verbosity     = 2'd0;
    m_ready       = 1'b0;
    s_level       = 8'h00;
    s_data[31:0]  = 32'hDEAD0000;
    s_valid       = 4'b0001;
    step();
    s_valid = '0;
    vectors++;
    if (m_valid !== 1'b1 || error_count !== 16'd1) begin miscompares++; $display("FAIL areset_pre got valid=%b cnt=%0d expected 1/1", m_valid, error_count); end
    #1;
    resetn = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || error_count !== 16'd0 || m_data !== 32'd0) begin
      miscompares++; $display("FAIL areset_clear got valid=%b cnt=%0d data=%h expected 0/0/0", m_valid, error_count, m_data);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_discard();
    test_backpressure();
    test_halt();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
